// File: rtl/int8_pkg.sv
// int8_pkg: shared types and defaults for the int8 vector loader.
//   bank_e  - host bank select (inputs, top weights, bottom weights, reserved)
//   state_e - loader sequencer states
//   DEF_WIDTH / DEF_NUM_INPUTS - default element width and vector length
package int8_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_NUM_INPUTS = 1024;

  typedef enum logic [1:0] {
    BANK_X    = 2'd0,
    BANK_T    = 2'd1,
    BANK_B    = 2'd2,
    BANK_RSVD = 2'd3
  } bank_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_e;

endpackage

// File: rtl/int8_bank_ram.sv
// int8_bank_ram: one element bank, single write port, single synchronous read.
//   clk, reset     - clock, async active-high reset (clears only the read register)
//   we/waddr/wdata - write port
//   re/raddr       - read request; rdata updates on the next edge and holds otherwise
//   rdata          - registered read data
module int8_bank_ram
  import int8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_NUM_INPUTS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Contents survive reset, so the array has no reset term.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Holding the read register when re=0 is what keeps the stream stable on stall.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/int8_vec_loader.sv
// int8_vec_loader: host-loaded x / weight_T / weight_B banks streamed out as
// (x, wt, wb) triples with a valid/ready handshake.
//   write/bank/addr/data_in - host writes, accepted in IDLE only, bank 3 reserved
//   start/busy/done         - stream control; done pulses once after the last handshake
//   out_valid/out_ready     - triple handshake; out_x/out_wt/out_wb/out_idx/out_last payload
//   err                     - sticky illegal-access flag
// Optional: define INT8_LOADER_READBACK_EN to add rd_en/rd_data bank readback.
module int8_vec_loader
  import int8_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SIGN       = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write,
  input  logic [1:0]                    bank,
  input  logic [$clog2(NUM_INPUTS)-1:0] addr,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          start,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_x,
  output logic [WIDTH-1:0]              out_wt,
  output logic [WIDTH-1:0]              out_wb,
  output logic [$clog2(NUM_INPUTS)-1:0] out_idx,
  output logic                          out_last,
  output logic                          done,
  output logic                          err
`ifdef INT8_LOADER_READBACK_EN
  ,
  input  logic                          rd_en,
  output logic [WIDTH:0]                rd_data
`endif
);

  localparam int AW = $clog2(NUM_INPUTS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_INPUTS - 1);

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] out_idx_q, out_idx_d;

  logic                  write_ok;
  logic [2:0]            we;
  logic                  ram_re;
  logic [AW-1:0]         ram_raddr;
  logic [2:0][WIDTH-1:0] rdata;
  logic [AW-1:0]         idx_nxt;
  logic                  hs;

  assign write_ok = write && (state_q == IDLE) && (bank_e'(bank) != BANK_RSVD);
  assign hs       = out_valid_q && out_ready;
  assign idx_nxt  = out_idx_q + 1'b1;

  for (genvar b = 0; b < 3; b++) begin : g_bank
    assign we[b] = write_ok && (bank == 2'(b));
    int8_bank_ram #(.WIDTH(WIDTH), .DEPTH(NUM_INPUTS)) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (we[b]),
      .waddr (addr),
      .wdata (data_in),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (rdata[b])
    );
  end

`ifdef INT8_LOADER_READBACK_EN
  logic             rd_hit_q, rd_hit_d;
  bank_e            rd_bank_q, rd_bank_d;
  logic [WIDTH-1:0] rd_sel;

  always_comb begin
    rd_hit_d  = rd_en && (state_q == IDLE) && (bank_e'(bank) != BANK_RSVD);
    rd_bank_d = bank_e'(bank);
    rd_sel    = '0;
    case (rd_bank_q)
      BANK_X:  rd_sel = rdata[0];
      BANK_T:  rd_sel = rdata[1];
      BANK_B:  rd_sel = rdata[2];
      default: rd_sel = '0;
    endcase
    rd_data = rd_hit_q ? {((SIGN != 0) ? rd_sel[WIDTH-1] : 1'b0), rd_sel} : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_hit_q  <= 1'b0;
      rd_bank_q <= BANK_X;
    end else begin
      rd_hit_q  <= rd_hit_d;
      rd_bank_q <= rd_bank_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    done_d      = 1'b0;
    err_d       = err_q | (write && ((state_q != IDLE) || (bank_e'(bank) == BANK_RSVD)));
    ram_re      = 1'b0;
    ram_raddr   = addr;
`ifdef INT8_LOADER_READBACK_EN
    err_d = err_d | (rd_en && (state_q != IDLE));
`endif
    case (state_q)
      IDLE: begin
`ifdef INT8_LOADER_READBACK_EN
        ram_re = rd_en;
`endif
        if (start) begin
          state_d   = PRIME;
          busy_d    = 1'b1;
          out_idx_d = '0;
        end
      end
      // Index 0 is read here rather than on the start edge so that a write
      // landing on that same edge is already in the bank.
      PRIME: begin
        ram_re      = 1'b1;
        ram_raddr   = '0;
        state_d     = STREAM;
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
      end
      STREAM: begin
        if (hs) begin
          if (out_last_q) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            ram_re     = 1'b1;
            ram_raddr  = idx_nxt;
            out_idx_d  = idx_nxt;
            out_last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;
  assign err       = err_q;
  assign out_x     = rdata[0];
  assign out_wt    = rdata[1];
  assign out_wb    = rdata[2];

endmodule

// File: doc/int8_vec_loader.md
INT8_VEC_LOADER -- requirements
Module: int8_vec_loader

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 1024: vector length, power of two, 2..4096.
REQ-002 SHALL have parameter WIDTH, default 8: element width in bits.
REQ-003 SHALL have parameter SIGN, default 1: 1 = signed elements, 0 = unsigned; affects only the readback sign-extension.
REQ-004 SHALL have port clk  input  1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port write  input  1: host write strobe.
REQ-007 SHALL have port bank  input  2: 0 = inputs, 1 = weights_T, 2 = weights_B, 3 = reserved.
REQ-008 SHALL have port addr  input  $clog2(NUM_INPUTS): element index.
REQ-009 SHALL have port data_in  input  WIDTH: write data.
REQ-010 SHALL have port start  input  1: request to stream all NUM_INPUTS triples.
REQ-011 SHALL have port busy  output  1: high from start acceptance until done.
REQ-012 SHALL have port out_valid  input-side handshake, output  1: triple valid.
REQ-013 SHALL have port out_ready  input  1: consumer accepts the triple.
REQ-014 SHALL have port out_x, out_wt, out_wb  output  WIDTH each: input, top weight and bottom weight at out_idx.
REQ-015 SHALL have port out_idx  output  $clog2(NUM_INPUTS): index of the current triple.
REQ-016 SHALL have port out_last  output  1: high with the triple at index NUM_INPUTS-1.
REQ-017 SHALL have port done  output  1: one-cycle pulse after the last handshake.
REQ-018 SHALL have port err  output  1: sticky flag for illegal writes.

Function
REQ-019 SHALL use states IDLE, PRIME and STREAM.
REQ-020 In IDLE, write=1 with bank<3 SHALL store data_in into the selected bank at addr at the clock edge.
REQ-021 A write with bank=3, or any write outside IDLE, SHALL be dropped and SHALL set err.
REQ-022 start in IDLE SHALL move to PRIME, assert busy on the next cycle, and issue a synchronous read of index 0 from all three banks.
REQ-023 Simultaneous write and start in IDLE: the write SHALL complete and start SHALL be accepted in the same cycle; the streamed data SHALL include the write.
REQ-024 PRIME SHALL last exactly one cycle, then move to STREAM with out_valid=1; the first out_valid SHALL be 2 cycles after the start edge.
REQ-025 A handshake occurs when out_valid and out_ready are both 1; it SHALL advance out_idx by 1 with the next triple valid the following cycle, giving one triple per cycle under constant out_ready.
REQ-026 While out_valid=1 and out_ready=0, out_x, out_wt, out_wb, out_idx and out_last SHALL hold stable.
REQ-027 A handshake at index NUM_INPUTS-1 SHALL clear out_valid next cycle, pulse done for 1 cycle, clear busy, and return to IDLE; the index SHALL NOT wrap to 0 on the stream.
REQ-028 start while busy SHALL be ignored.
REQ-029 Bank contents SHALL persist across streams.

Reset
REQ-030 Reset SHALL force IDLE and set busy, out_valid, out_last, done, err and out_idx to 0 and out_x/out_wt/out_wb to 0; bank contents are not reset.
REQ-031 Reset asserted mid-stream SHALL abort immediately with no done pulse; a later start SHALL restart from index 0.

Configuration
REQ-032 With macro INT8_LOADER_READBACK_EN defined, the module SHALL add ports rd_en (input, 1) and rd_data (output, WIDTH+1): in IDLE, rd_en returns bank[bank][addr] one cycle later, sign-extended when SIGN=1 and zero-extended otherwise; rd_en outside IDLE returns 0 and sets err.
REQ-033 Without the macro, those ports and their read mux SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-034 A shared package int8_pkg SHALL hold the bank-select enum (BANK_X, BANK_T, BANK_B, BANK_RSVD), the state enum, and default WIDTH/NUM_INPUTS constants.
REQ-035 One sub-module, int8_bank_ram, SHALL implement a single-write, single-sync-read bank and be instantiated three times.

Verification
REQ-036 Write x[i]=i, wt[i]=-i, wb[i]=2i for NUM_INPUTS=16, then start with out_ready=1 -> 16 consecutive triples (i, -i, 2i), out_last only at idx 15, done 1 cycle after, first valid 2 cycles after start.
REQ-037 Same stream with out_ready toggling 1,0,0,1 -> no triple lost or duplicated, outputs stable while stalled, 16 handshakes total.
REQ-038 Write during STREAM (bank 0, addr 3, 0x7F) -> err=1 and streamed x[3] keeps its old value.
REQ-039 Assert reset at idx 7 mid-stream -> outputs 0 immediately with no done; restart -> stream begins at idx 0 with the original data.
REQ-040 Simultaneous write (bank 1, addr 0, 0x80) and start -> first triple has out_wt=0x80; start pulsed while busy -> ignored.
REQ-041 With INT8_LOADER_READBACK_EN and SIGN=1, readback of 0x80 -> rd_data=0x180 one cycle later.
